// File: rtl/axis_pkt_limiter.sv
// axis_pkt_limiter: AXI-Stream max-packet-length limiter with registered, skid-buffered outputs
// Ports: clk/rst (sync, active-high); s_axis_* input stream; m_axis_* output stream;
//   stat_pkt_count / stat_trunc_count / stat_drop_beats statistics.
// Oversized packets are cut at MAX_BEATS (tlast forced, tuser[0] set), the remainder is dropped.
// Define AXIS_PKT_LIMITER_STATS_EN to build the statistics counters; otherwise stat_* read 0.
module axis_pkt_limiter #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
  parameter int ID_WIDTH   = 8,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 1,
  parameter int MAX_BEATS  = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [ID_WIDTH-1:0]   s_axis_tid,
  input  logic [DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [ID_WIDTH-1:0]   m_axis_tid,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic [CNT_WIDTH-1:0]  stat_pkt_count,
  output logic [CNT_WIDTH-1:0]  stat_trunc_count,
  output logic [CNT_WIDTH-1:0]  stat_drop_beats
);
  localparam int BW = $clog2(MAX_BEATS + 1);
  localparam int PW = DATA_WIDTH + KEEP_WIDTH + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;
  typedef enum logic {PASS, DROP} state_t;
  state_t state, state_nx;
  logic [BW-1:0] beat_cnt, beat_cnt_nx;
  logic [PW-1:0] out_reg, skid_reg, beat_in;
  logic [USER_WIDTH-1:0] user_o;
  logic s_ready, m_valid, sk_valid, m_valid_nx, sk_valid_nx;
  logic acc, take, emit, force_last, last_o, out_free;
  always_comb begin
    acc = s_axis_tvalid && s_ready;
    take = m_valid && m_axis_tready;
    emit = acc && state == PASS;
    force_last = (beat_cnt + BW'(1) == BW'(MAX_BEATS)) && !s_axis_tlast;
    last_o = s_axis_tlast || force_last;
    user_o = s_axis_tuser | USER_WIDTH'(force_last);
    beat_in = {s_axis_tdata, s_axis_tkeep, last_o, s_axis_tid, s_axis_tdest, user_o};
    out_free = !m_valid || take;
    m_valid_nx = sk_valid || emit || (m_valid && !take);
    sk_valid_nx = (sk_valid || emit) && !out_free;
    beat_cnt_nx = emit ? (last_o ? '0 : beat_cnt + BW'(1)) : beat_cnt;
    state_nx = state;
    if (emit && force_last) state_nx = DROP;
    if (acc && state == DROP && s_axis_tlast) state_nx = PASS;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PASS;
      beat_cnt <= '0;
      m_valid <= 1'b0;
      sk_valid <= 1'b0;
      s_ready <= 1'b0;
      out_reg <= '0;
      skid_reg <= '0;
    end else begin
      state <= state_nx;
      beat_cnt <= beat_cnt_nx;
      m_valid <= m_valid_nx;
      sk_valid <= sk_valid_nx;
      // DROP swallows everything, so input may stay open even with the skid occupied
      s_ready <= state_nx == DROP || !sk_valid_nx;
      if (sk_valid && out_free) out_reg <= skid_reg;
      else if (emit && out_free) out_reg <= beat_in;
      if (emit && !out_free) skid_reg <= beat_in;
    end
  end
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tdest, m_axis_tuser} = out_reg;
  assign m_axis_tvalid = m_valid;
  assign s_axis_tready = s_ready;
`ifdef AXIS_PKT_LIMITER_STATS_EN
  logic out_forced, sk_forced;
  logic [CNT_WIDTH-1:0] pkt_cnt, trunc_cnt, drop_cnt;
  // forced flag travels with the beat, since tuser[0] may already be set by the source
  always_ff @(posedge clk) begin
    if (rst) begin
      out_forced <= 1'b0;
      sk_forced <= 1'b0;
      pkt_cnt <= '0;
      trunc_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (sk_valid && out_free) out_forced <= sk_forced;
      else if (emit && out_free) out_forced <= force_last;
      if (emit && !out_free) sk_forced <= force_last;
      if (take && m_axis_tlast) pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
      if (take && out_forced) trunc_cnt <= trunc_cnt + CNT_WIDTH'(1);
      if (acc && state == DROP) drop_cnt <= drop_cnt + CNT_WIDTH'(1);
    end
  end
  assign stat_pkt_count = pkt_cnt;
  assign stat_trunc_count = trunc_cnt;
  assign stat_drop_beats = drop_cnt;
`else
  assign stat_pkt_count = '0;
  assign stat_trunc_count = '0;
  assign stat_drop_beats = '0;
`endif
endmodule

// File: tb/tb_axis_pkt_limiter.sv
// tb_axis_pkt_limiter: directed self-checking bench for axis_pkt_limiter (MAX_BEATS=16 and MAX_BEATS=1)
module tb_axis_pkt_limiter;
`ifdef AXIS_PKT_LIMITER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 0, rst = 1;
  logic [63:0] s_tdata = 0;
  logic [7:0] s_tkeep = 8'hFF, s_tid = 0, s_tdest = 0;
  logic s_tvalid = 0, s_tlast = 0, s_tready, m_tready = 1;
  logic [0:0] s_tuser = 0;
  logic [63:0] m_tdata;
  logic [7:0] m_tkeep, m_tid, m_tdest;
  logic m_tvalid, m_tlast;
  logic [0:0] m_tuser;
  logic [31:0] st_pkt, st_trunc, st_drop;
  logic b_valid = 0, b_ready, b_mvalid, b_mlast;
  logic [63:0] b_mdata;
  logic [7:0] b_mkeep, b_mid, b_mdest;
  logic [0:0] b_muser;
  logic [31:0] b_pkt, b_trunc, b_drop;
  typedef struct {logic [63:0] d; logic [7:0] k; logic l; logic [7:0] id; logic [7:0] de; logic u; int c;} beat_t;
  beat_t q[$], qb[$];
  int cyc = 0, checks = 0, errors = 0, first_acc = -1;
  logic held = 0;
  logic [89:0] hv = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  axis_pkt_limiter #(.MAX_BEATS(16)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast), .s_axis_tid(s_tid), .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .m_axis_tid(m_tid), .m_axis_tdest(m_tdest), .m_axis_tuser(m_tuser),
    .stat_pkt_count(st_pkt), .stat_trunc_count(st_trunc), .stat_drop_beats(st_drop));
  axis_pkt_limiter #(.MAX_BEATS(1)) dut1 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(b_valid), .s_axis_tready(b_ready),
    .s_axis_tlast(s_tlast), .s_axis_tid(s_tid), .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
    .m_axis_tdata(b_mdata), .m_axis_tkeep(b_mkeep), .m_axis_tvalid(b_mvalid), .m_axis_tready(1'b1),
    .m_axis_tlast(b_mlast), .m_axis_tid(b_mid), .m_axis_tdest(b_mdest), .m_axis_tuser(b_muser),
    .stat_pkt_count(b_pkt), .stat_trunc_count(b_trunc), .stat_drop_beats(b_drop));
  always @(negedge clk) begin
    if (held) begin
      checks++;
      assert ({m_tvalid, m_tdata, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser} === {1'b1, hv})
        else begin errors++; $error("FAIL stall_hold observed=%0h expected=%0h", {m_tvalid, m_tdata}, {1'b1, hv[89:26]}); end
    end
    held = m_tvalid && !m_tready;
    hv = {m_tdata, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser};
    if (m_tvalid && m_tready) q.push_back('{m_tdata, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser[0], cyc});
    if (b_mvalid) qb.push_back('{b_mdata, b_mkeep, b_mlast, b_mid, b_mdest, b_muser[0], cyc});
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin errors++; $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); end
  endtask
  task automatic beat(input logic bsel, input logic [63:0] d, input logic l);
    int t = 0;
    s_tdata = d;
    s_tlast = l;
    if (bsel) b_valid = 1; else s_tvalid = 1;
    @(negedge clk);
    while (!(bsel ? b_ready : s_tready) && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) begin checks++; errors++; $error("FAIL accept_timeout observed=not_ready expected=ready"); end
    @(posedge clk); #1;
    if (first_acc < 0) first_acc = cyc;
    s_tvalid = 0;
    b_valid = 0;
  endtask
  task automatic pkt(input logic bsel, input int n, input logic [63:0] base);
    for (int i = 0; i < n; i++) beat(bsel, base + 64'(i), i == n - 1);
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mvalid", m_tvalid, 0);
    chk("rst_sready", s_tready, 0);
    chk("rst_mdata", m_tdata, 0);
    chk("rst_mlast_user", {m_tlast, m_tuser}, 0);
    chk("rst_stat_pkt", st_pkt, 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("sready_release_same", s_tready, 0);
    @(negedge clk);
    chk("sready_release_next", s_tready, 1);
    @(posedge clk); #1;
    // 4-beat packet, full rate
    s_tid = 8'h5A; s_tdest = 8'hA5;
    q.delete(); first_acc = -1;
    pkt(0, 4, 64'h100);
    idle(4);
    chk("p4_count", q.size(), 4);
    chk("p4_latency", q[0].c, first_acc);
    chk("p4_id_dest_keep", {q[0].id, q[0].de, q[0].k}, 24'h5AA5FF);
    for (int i = 0; i < 4; i++) begin
      chk("p4_data", q[i].d, 64'h100 + 64'(i));
      chk("p4_last_user", {q[i].l, q[i].u}, {i == 3, 1'b0});
      chk("p4_rate", q[i].c, first_acc + i);
    end
    // exactly MAX_BEATS
    q.delete();
    pkt(0, 16, 64'h200);
    idle(4);
    chk("p16_count", q.size(), 16);
    for (int i = 0; i < 16; i++) begin
      chk("p16_data", q[i].d, 64'h200 + 64'(i));
      chk("p16_last_user", {q[i].l, q[i].u}, {i == 15, 1'b0});
    end
    chk("p16_trunc", st_trunc, 0);
    // 20-beat truncated then 2-beat intact
    q.delete();
    pkt(0, 20, 64'h300);
    pkt(0, 2, 64'h400);
    idle(4);
    chk("p20_count", q.size(), 18);
    for (int i = 0; i < 16; i++) begin
      chk("p20_data", q[i].d, 64'h300 + 64'(i));
      chk("p20_last_user", {q[i].l, q[i].u}, {i == 15, i == 15});
    end
    for (int i = 16; i < 18; i++) begin
      chk("p2_data", q[i].d, 64'h400 + 64'(i - 16));
      chk("p2_last_user", {q[i].l, q[i].u}, {i == 17, 1'b0});
    end
    chk("stat_pkt", st_pkt, STATS ? 4 : 0);
    chk("stat_trunc", st_trunc, STATS ? 1 : 0);
    chk("stat_drop", st_drop, STATS ? 4 : 0);
    // truncation under output back-pressure
    q.delete();
    fork
      pkt(0, 20, 64'h500);
      for (int i = 0; i < 60; i++) begin
        @(posedge clk); #1 m_tready = (i % 4) < 2;
      end
    join
    m_tready = 1;
    pkt(0, 2, 64'h600);
    idle(4);
    chk("stall_count", q.size(), 18);
    for (int i = 0; i < 16; i++) begin
      chk("stall_data", q[i].d, 64'h500 + 64'(i));
      chk("stall_last_user", {q[i].l, q[i].u}, {i == 15, i == 15});
    end
    chk("stall_next_pkt", {q[16].d[15:0], q[17].d[15:0], q[17].l}, {16'h600, 16'h601, 1'b1});
    // MAX_BEATS=1 instance
    qb.delete();
    pkt(1, 3, 64'h700);
    pkt(1, 1, 64'h800);
    idle(3);
    chk("mb1_count", qb.size(), 2);
    chk("mb1_cut", {qb[0].d, qb[0].l, qb[0].u}, {64'h700, 1'b1, 1'b1});
    chk("mb1_single", {qb[1].d, qb[1].l, qb[1].u}, {64'h800, 1'b1, 1'b0});
    chk("mb1_stats", {b_pkt[7:0], b_trunc[7:0], b_drop[7:0]}, STATS ? 24'h020102 : 24'h0);
    // reset during beat 5 of a 20-beat packet
    for (int i = 0; i < 4; i++) beat(0, 64'h900 + 64'(i), 0);
    s_tdata = 64'h904; s_tlast = 0; s_tvalid = 1; rst = 1;
    @(posedge clk); #1 rst = 0; s_tvalid = 0;
    @(negedge clk);
    chk("midrst_mvalid", m_tvalid, 0);
    chk("midrst_sready", s_tready, 0);
    chk("midrst_stat", st_pkt, 0);
    @(posedge clk); #1;
    q.delete();
    pkt(0, 3, 64'hA00);
    idle(4);
    chk("midrst_count", q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk("midrst_data", q[i].d, 64'hA00 + 64'(i));
      chk("midrst_last_user", {q[i].l, q[i].u}, {i == 2, 1'b0});
    end
    chk("midrst_stat_pkt", st_pkt, STATS ? 1 : 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axis_pkt_limiter.md
Name: axis_pkt_limiter

Overview:
- Single-clock AXI-Stream stage that sits directly downstream of the clock-crossing FIFO, in the read-clock domain.
- Enforces a maximum packet length in beats. Packets within the limit pass unchanged.
- An oversized packet is cut at MAX_BEATS: that beat goes out with tlast forced high and an error flag on tuser[0], and the rest of the input packet is discarded.
- Outputs are fully registered through a skid buffer, so the stage also acts as a timing break before downstream logic.

Parameters:
- DATA_WIDTH, 64, tdata width.
- KEEP_WIDTH, (DATA_WIDTH+7)/8, tkeep width.
- ID_WIDTH, 8, tid width.
- DEST_WIDTH, 8, tdest width.
- USER_WIDTH, 1, tuser width; must be >= 1, and bit 0 is the error flag.
- MAX_BEATS, 16, maximum beats per output packet; must be >= 1.
- CNT_WIDTH, 32, width of the statistics counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- s_axis_tdata  in  DATA_WIDTH  input data
- s_axis_tkeep  in  KEEP_WIDTH  input byte enables
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  input end of packet
- s_axis_tid  in  ID_WIDTH  input id
- s_axis_tdest  in  DEST_WIDTH  input dest
- s_axis_tuser  in  USER_WIDTH  input user
- m_axis_tdata  out  DATA_WIDTH  output data
- m_axis_tkeep  out  KEEP_WIDTH  output byte enables
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  output end of packet
- m_axis_tid  out  ID_WIDTH  output id
- m_axis_tdest  out  DEST_WIDTH  output dest
- m_axis_tuser  out  USER_WIDTH  output user
- stat_pkt_count  out  CNT_WIDTH  packets emitted
- stat_trunc_count  out  CNT_WIDTH  packets truncated
- stat_drop_beats  out  CNT_WIDTH  beats discarded

Behaviour:
- Interface: one clock (clk); rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - m_axis_tvalid=0, s_axis_tready=0, state=PASS, beat_cnt=0, skid buffer empty, all stat counters 0.
  - m_axis data, keep, last, id, dest and user fields are 0.
  - s_axis_tready rises the cycle after rst is released.
- Handshakes:
  - Input beat accepted when s_axis_tvalid && s_axis_tready.
  - Output beat taken when m_axis_tvalid && m_axis_tready.
  - m_axis_tvalid never drops, and m_axis fields never change, while m_axis_tvalid && !m_axis_tready.
- Datapath: output register plus one skid register.
  - Latency 1 cycle, input accept to m_axis_tvalid.
  - s_axis_tready is registered and equals !skid_valid in PASS.
  - Sustains 1 beat/clk with m_axis_tready held high.
  - When m_axis_tready deasserts, one beat already in flight is captured in skid; no beat is lost or duplicated.
- beat_cnt: width clog2(MAX_BEATS+1).
  - Increments on each accepted beat in PASS.
  - Clears on any accepted beat that is emitted with tlast high.
- State PASS:
  - Accepted beat with beat_cnt+1 < MAX_BEATS, or with s_axis_tlast=1: forwarded unchanged.
  - Accepted beat with beat_cnt+1 == MAX_BEATS and s_axis_tlast=0: forwarded with m_axis_tlast=1 and m_axis_tuser[0] = s_axis_tuser[0] | 1; other tuser bits unchanged. Then go to DROP.
- State DROP:
  - s_axis_tready=1 unconditionally; accepted beats are discarded and not emitted.
  - The beat with s_axis_tlast=1 is discarded and returns the state to PASS, with beat_cnt=0.
  - If the skid is occupied on DROP exit, s_axis_tready follows the PASS rule from the next cycle.
- MAX_BEATS=1: every non-last beat is emitted as a single-beat packet with the error flag set; remaining beats are dropped.
- tid and tdest are passed through with no per-packet consistency check.
- Reset mid-packet: buffered beats are discarded, state returns to PASS with beat_cnt=0, and the next accepted beat is treated as the start of a packet.
- Simultaneous input accept and output take with the skid empty: the output register loads the new beat in the same edge.

Optional Feature:
- Macro: AXIS_PKT_LIMITER_STATS_EN.
- Defined:
  - stat_pkt_count increments on each output beat taken with m_axis_tlast=1.
  - stat_trunc_count increments when a forced-tlast beat is taken.
  - stat_drop_beats increments on each beat discarded in DROP.
  - All counters wrap at 2^CNT_WIDTH and are cleared by rst.
- Not defined: all stat_* outputs are tied to 0 and no counter logic is synthesised.

Test Plan:
- MAX_BEATS=16, 4-beat packet, m_axis_tready=1 -> 4 identical beats out, tlast on beat 4, tuser[0]=0, first m_axis_tvalid 1 cycle after the first accept, 1 beat/clk.
- MAX_BEATS=16, exactly 16-beat packet with tlast on beat 16 -> passes unmodified, tuser[0]=0, stat_trunc_count stays 0.
- MAX_BEATS=16, 20-beat packet followed by a 2-beat packet -> 16 beats out, beat 16 with tlast=1 and tuser[0]=1; beats 17-20 dropped; 2-beat packet intact. With stats: pkt_count=2, trunc_count=1, drop_beats=4.
- Random m_axis_tready (50%), 100 packets of 1-30 beats, MAX_BEATS=8 -> scoreboard matches the expected truncation, no lost or duplicated beats, outputs stable while stalled.
- MAX_BEATS=1, 3-beat packet -> 1 beat out with tlast=1 and tuser[0]=1; 2 beats dropped.
- rst pulsed during beat 5 of a 20-beat packet (MAX_BEATS=16) -> m_axis_tvalid=0 the next cycle; a following 3-beat packet is forwarded intact with no error flag.
